// File: rtl/fwrisc_fetch_pf.sv
// Prefetching instruction fetch for fwrisc: single-outstanding bus fetch into a small
// word FIFO, with extraction of 16-bit and (possibly misaligned) 32-bit instructions.
module fwrisc_fetch_pf #(
    parameter bit          ENABLE_COMPRESSED = 1'b1,
    parameter int unsigned FIFO_DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:1] next_pc,
    input  logic        next_pc_seq,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic        ivalid,
    input  logic        iready,
    output logic        fetch_valid,
    input  logic        decode_ready,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] pc
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] PC_MASK = ENABLE_COMPRESSED ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   iaddr_q, iaddr_d;
    logic [31:0]   tgt_q, tgt_d;
    logic          req_q, req_d;
    logic          discard_q, discard_d;
    logic          fv_q, fv_d;
    logic          instr_c_q, instr_c_d;
    logic [31:0]   instr_q, instr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];

    // FIFO contents after this cycle's pop, padded so entry 1 always exists
    logic [31:0]   mem_x [FIFO_DEPTH+1];
    logic [CW-1:0] avail;
    logic          xfer, hold, accept, redirect, pop;
    logic [31:0]   pc_inc, tgt_pc, tgt_addr, word0;
    logic [15:0]   word1_lo, hw;

    always_comb begin
        xfer     = req_q & iready;
        hold     = req_q & ~iready;
        accept   = fv_q & decode_ready;
        redirect = accept & ~next_pc_seq;
        pc_inc   = pc_q + (instr_c_q ? 32'd2 : 32'd4);
        pop      = accept & next_pc_seq & (pc_inc[31:2] != pc_q[31:2]);
        tgt_pc   = {next_pc, 1'b0} & PC_MASK;
        tgt_addr = {next_pc[31:2], 2'b00};

        mem_x[FIFO_DEPTH] = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_x[i] = mem_q[i];
        end
        if (pop) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                mem_x[i] = mem_q[i+1];
            end
            mem_x[FIFO_DEPTH-1] = '0;
        end
        avail = redirect ? '0 : (count_q - CW'(pop));

        // Push lands behind the surviving entries; dropped when stale or redirecting
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_x[i];
        end
        count_d = avail;
        if (xfer && !discard_q && !redirect) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == avail) begin
                    mem_d[i] = idata;
                end
            end
            count_d = avail + CW'(1);
        end

        iaddr_d   = iaddr_q;
        tgt_d     = tgt_q;
        discard_d = discard_q;
        if (redirect) begin
            if (hold) begin
                discard_d = 1'b1;
                tgt_d     = tgt_addr;
            end else begin
                discard_d = 1'b0;
                iaddr_d   = tgt_addr;
            end
        end else if (xfer) begin
            if (discard_q) begin
                discard_d = 1'b0;
                iaddr_d   = tgt_q;
            end else begin
                iaddr_d = iaddr_q + 32'd4;
            end
        end
        req_d = hold | discard_d | (count_d < CW'(FIFO_DEPTH));

        pc_d = pc_q;
        if (redirect) begin
            pc_d = tgt_pc;
        end else if (accept) begin
            pc_d = pc_inc;
        end

        // Present only from words already held; this cycle's push shows up next cycle
        word0     = mem_x[0];
        word1_lo  = mem_x[1][15:0];
        hw        = pc_d[1] ? word0[31:16] : word0[15:0];
        fv_d      = 1'b0;
        instr_d   = '0;
        instr_c_d = 1'b0;
        if (avail != '0) begin
            if (ENABLE_COMPRESSED && (hw[1:0] != 2'b11)) begin
                fv_d      = 1'b1;
                instr_d   = {16'h0000, hw};
                instr_c_d = 1'b1;
            end else if (!pc_d[1]) begin
                fv_d    = 1'b1;
                instr_d = word0;
            end else if (avail > CW'(1)) begin
                fv_d    = 1'b1;
                instr_d = {word1_lo, word0[31:16]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR & PC_MASK;
            iaddr_q   <= RESET_VECTOR & 32'hFFFF_FFFC;
            tgt_q     <= RESET_VECTOR & 32'hFFFF_FFFC;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            fv_q      <= 1'b0;
            instr_q   <= '0;
            instr_c_q <= 1'b0;
            count_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            iaddr_q   <= iaddr_d;
            tgt_q     <= tgt_d;
            req_q     <= req_d;
            discard_q <= discard_d;
            fv_q      <= fv_d;
            instr_q   <= instr_d;
            instr_c_q <= instr_c_d;
            count_q   <= count_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign iaddr       = iaddr_q;
    assign ivalid      = req_q;
    assign fetch_valid = fv_q;
    assign instr       = instr_q;
    assign instr_c     = instr_c_q;
    assign pc          = pc_q;
endmodule

// File: tb/tb_fwrisc_fetch_pf.sv
// Bench for fwrisc_fetch_pf: directed fetch/extract/redirect/reset scenarios, then a
// randomized run checked against a halfword-memory instruction-stream model.
module tb_fwrisc_fetch_pf;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:1] next_pc;
    logic        next_pc_seq;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        ivalid;
    logic        iready;
    logic        fetch_valid;
    logic        decode_ready;
    logic [31:0] instr;
    logic        instr_c;
    logic [31:0] pc;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prog [0:255];
    logic [31:0] xq [$];
    logic [31:0] acc_pc [$];
    logic [31:0] acc_instr [$];
    logic [31:0] acc_c [$];

    fwrisc_fetch_pf dut (
        .clock(clock), .reset(reset), .next_pc(next_pc), .next_pc_seq(next_pc_seq),
        .iaddr(iaddr), .idata(idata), .ivalid(ivalid), .iready(iready),
        .fetch_valid(fetch_valid), .decode_ready(decode_ready),
        .instr(instr), .instr_c(instr_c), .pc(pc)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers the current address, transfers/accepts are logged
    task automatic step();
        idata = prog[iaddr[9:2]];
        if (ivalid && iready) xq.push_back(iaddr);
        if (fetch_valid && decode_ready) begin
            acc_pc.push_back(pc);
            acc_instr.push_back(instr);
            acc_c.push_back(32'(instr_c));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        xq.delete();
        acc_pc.delete();
        acc_instr.delete();
        acc_c.delete();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        iready       = 1'b0;
        decode_ready = 1'b0;
        next_pc_seq  = 1'b1;
        next_pc      = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic run_accepts(input int n, input int budget, input string tag);
        int k = 0;
        while (acc_pc.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(acc_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_fv(input int budget, input string tag);
        int k = 0;
        while (!fetch_valid && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(fetch_valid), 32'd1);
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = prog[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction at address a viewed as a halfword stream
    task automatic model(input logic [31:0] a, output logic [31:0] i, output logic c);
        logic [15:0] h0, h1;
        h0 = hw_at(a);
        h1 = hw_at(a + 32'd2);
        if (h0[1:0] != 2'b11) begin
            i = {16'h0000, h0};
            c = 1'b1;
        end else begin
            i = {h1, h0};
            c = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] exp_pc, ei, prev_addr;
        logic        ec, redir, acc, prev_hold;
        int          n_acc, zero_cnt;

        for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;

        // Sequential 32-bit words, reset values, fill latency
        prog[0] = 32'h00A00593; prog[1] = 32'h00B00613; prog[2] = 32'h00C00693;
        reset = 1'b1; iready = 1'b0; decode_ready = 1'b0; next_pc_seq = 1'b1; next_pc = '0;
        @(posedge clock);
        #1;
        chk("rst_ivalid", 32'(ivalid), 32'd0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_c", 32'(instr_c), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        reset = 1'b0;
        clear_logs();
        chk("a_c0_ivalid", 32'(ivalid), 32'd0);
        iready = 1'b1; decode_ready = 1'b1;
        step();
        chk("a_c1_ivalid", 32'(ivalid), 32'd1);
        chk("a_c1_iaddr", iaddr, 32'd0);
        step();
        chk("a_c2_fv_latency", 32'(fetch_valid), 32'd0);
        chk("a_c2_iaddr", iaddr, 32'd4);
        step();
        chk("a_c3_fv", 32'(fetch_valid), 32'd1);
        chk("a_c3_instr", instr, 32'h00A00593);
        run_accepts(3, 20, "a_accepts");
        chk("a_pc0", acc_pc[0], 32'd0);
        chk("a_pc1", acc_pc[1], 32'd4);
        chk("a_pc2", acc_pc[2], 32'd8);
        chk("a_instr1", acc_instr[1], 32'h00B00613);
        chk("a_instr2", acc_instr[2], 32'h00C00693);
        chk("a_c_all", acc_c[0] | acc_c[1] | acc_c[2], 32'd0);
        chk("a_xfer0", xq[0], 32'd0);
        chk("a_xfer1", xq[1], 32'd4);
        chk("a_xfer2", xq[2], 32'd8);

        // Two compressed instructions in one word
        prog[0] = 32'h45054501;
        do_reset();
        iready = 1'b1; decode_ready = 1'b1;
        run_accepts(2, 20, "b_accepts");
        chk("b_instr0", acc_instr[0], 32'h00004501);
        chk("b_instr1", acc_instr[1], 32'h00004505);
        chk("b_pc1", acc_pc[1], 32'd2);
        chk("b_c", acc_c[0] & acc_c[1], 32'd1);
        zero_cnt = 0;
        foreach (xq[i]) if (xq[i] == 32'd0) zero_cnt++;
        chk("b_one_xfer", 32'(zero_cnt), 32'd1);

        // Misaligned 32-bit instruction waits for its second word
        prog[0] = 32'h05934501; prog[1] = 32'h000000A0;
        do_reset();
        iready = 1'b1; decode_ready = 1'b1;
        step();
        step();
        iready = 1'b0;
        chk("c_iaddr4", iaddr, 32'd4);
        step();
        chk("c_instr0", instr, 32'h00004501);
        chk("c_c0", 32'(instr_c), 32'd1);
        step();
        step(); step(); step();
        chk("c_wait_w2", 32'(fetch_valid), 32'd0);
        iready = 1'b1;
        step();
        chk("c_same_cycle", 32'(fetch_valid), 32'd0);
        step();
        chk("c_fv", 32'(fetch_valid), 32'd1);
        chk("c_instr1", instr, 32'h00A00593);
        chk("c_c1", 32'(instr_c), 32'd0);
        chk("c_pc1", pc, 32'd2);

        // Redirect while a request is stalled: old transfer completes and is discarded
        prog[0] = 32'h00A00593; prog[1] = 32'h00B00613; prog[2] = 32'h00E00793;
        prog[64] = 32'h00D00713;
        do_reset();
        iready = 1'b1;
        step(); step(); step();
        iready = 1'b0; decode_ready = 1'b1;
        step();
        chk("d_req8", iaddr, 32'd8);
        chk("d_req8_valid", 32'(ivalid), 32'd1);
        next_pc_seq = 1'b0; next_pc = 31'h80;
        step();
        next_pc_seq = 1'b1; decode_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("d_hold_addr", iaddr, 32'd8);
            chk("d_hold_valid", 32'(ivalid), 32'd1);
            chk("d_no_fv", 32'(fetch_valid), 32'd0);
            step();
        end
        iready = 1'b1;
        step();
        chk("d_new_addr", iaddr, 32'h100);
        chk("d_new_valid", 32'(ivalid), 32'd1);
        wait_fv(10, "d_fv");
        chk("d_pc", pc, 32'h100);
        chk("d_instr", instr, 32'h00D00713);

        // Redirect to a halfword target
        prog[64] = 32'h45010000;
        do_reset();
        iready = 1'b1;
        wait_fv(10, "e_fv_first");
        next_pc_seq = 1'b0; next_pc = 31'h81; decode_ready = 1'b1;
        xq.delete();
        step();
        next_pc_seq = 1'b1; decode_ready = 1'b0;
        chk("e_fv0", 32'(fetch_valid), 32'd0);
        wait_fv(10, "e_fv");
        chk("e_pc", pc, 32'h102);
        chk("e_instr", instr, 32'h00004501);
        chk("e_c", 32'(instr_c), 32'd1);
        chk("e_xfer", xq[0], 32'h100);

        // Decode stall fills the FIFO, then reset mid-request
        do_reset();
        iready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k >= 3) chk("f_hold_instr", instr, 32'h00A00593);
        end
        chk("f_xfers", 32'(xq.size()), 32'd2);
        chk("f_ivalid_low", 32'(ivalid), 32'd0);
        decode_ready = 1'b1;
        step();
        decode_ready = 1'b0; iready = 1'b0;
        chk("f_req", 32'(ivalid), 32'd1);
        reset = 1'b1;
        #1;
        chk("f_rst_ivalid", 32'(ivalid), 32'd0);
        chk("f_rst_fv", 32'(fetch_valid), 32'd0);
        chk("f_rst_instr", instr, 32'd0);
        chk("f_rst_iaddr", iaddr, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        iready = 1'b1;
        step();
        chk("f_restart_valid", 32'(ivalid), 32'd1);
        chk("f_restart_addr", iaddr, 32'd0);

        // Randomized traffic against the instruction-stream model
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        do_reset();
        exp_pc = 32'd0; n_acc = 0; prev_hold = 1'b0; prev_addr = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iready       = ($urandom_range(0, 3) != 0);
            decode_ready = ($urandom_range(0, 2) != 0);
            redir        = ($urandom_range(0, 9) == 0);
            next_pc_seq  = !redir;
            next_pc      = 31'($urandom_range(0, 511));
            ec = 1'b0;
            if (fetch_valid) begin
                model(exp_pc, ei, ec);
                chk("r_pc", pc, exp_pc);
                chk("r_instr", instr, ei);
                chk("r_instr_c", 32'(instr_c), 32'(ec));
            end
            if (prev_hold) begin
                chk("r_hold_valid", 32'(ivalid), 32'd1);
                chk("r_hold_addr", iaddr, prev_addr);
            end
            acc       = fetch_valid && decode_ready;
            prev_hold = ivalid && !iready;
            prev_addr = iaddr;
            step();
            if (acc) begin
                n_acc++;
                if (redir) begin
                    exp_pc = {next_pc, 1'b0};
                    chk("r_redir_fv0", 32'(fetch_valid), 32'd0);
                end else begin
                    exp_pc = exp_pc + (ec ? 32'd2 : 32'd4);
                end
            end
        end
        chk("r_progress", 32'(n_acc > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
